// File: rtl/alu_cmd_issuer_pkg.sv
// Shared definitions for the 4-bit ALU port: datapath widths, opcodes,
// issuer FSM state encodings and the opcode legality check.
// Imported by the issuer and by anything else that decodes ALU opcodes.
package alu_cmd_issuer_pkg;

   localparam int DATA_W = 4;   // operand / accumulator width
   localparam int RES_W  = 5;   // ALU result width (carry/borrow/invert in bit 4)

   localparam logic [DATA_W-1:0] OP_ADD  = 4'd3;
   localparam logic [DATA_W-1:0] OP_SUB  = 4'd4;
   localparam logic [DATA_W-1:0] OP_AND  = 4'd5;
   localparam logic [DATA_W-1:0] OP_NAND = 4'd6;
   localparam logic [DATA_W-1:0] OP_OR   = 4'd7;
   localparam logic [DATA_W-1:0] OP_NOR  = 4'd8;
   localparam logic [DATA_W-1:0] OP_XOR  = 4'd9;
   localparam logic [DATA_W-1:0] OP_XNOR = 4'd10;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SETTLE = 2'd1;
   localparam logic [1:0] ST_RESP   = 2'd2;

   // The legal opcodes form one contiguous range, ADD..XNOR.
   function automatic logic is_legal_op(input logic [DATA_W-1:0] op);
      return (op >= OP_ADD) && (op <= OP_XNOR);
   endfunction

endpackage

// File: rtl/alu_cmd_issuer.sv
// Purpose : issue valid/ready commands to the combinational 4-bit ALU, capture
//           alu_out after SETTLE_CYCLES and return it on a response channel;
//           keeps a 4-bit accumulator for chained ops, rejects illegal opcodes.
// Latency : rsp_valid SETTLE_CYCLES+1 cycles after the accept cycle (legal),
//           1 cycle after accept (illegal opcode).
// Backpr. : one command in flight; cmd_ready only in IDLE; response and alu_*
//           held until rsp_ready, then one idle cycle before the next accept.
// Ports   : clk/rst_n (async active-low); cmd_valid/cmd_ready/cmd_opcode/
//           cmd_a/cmd_b/cmd_use_acc command channel; alu_in_a/alu_in_b/
//           alu_opcode/alu_out ALU port; rsp_valid/rsp_ready/rsp_result/
//           rsp_zero/rsp_err response channel; acc accumulator.
module alu_cmd_issuer
   import alu_cmd_issuer_pkg::*;
#(
   parameter int SETTLE_CYCLES = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [DATA_W-1:0] cmd_opcode,
   input  logic [DATA_W-1:0] cmd_a,
   input  logic [DATA_W-1:0] cmd_b,
   input  logic              cmd_use_acc,
   output logic [DATA_W-1:0] alu_in_a,
   output logic [DATA_W-1:0] alu_in_b,
   output logic [DATA_W-1:0] alu_opcode,
   input  logic [RES_W-1:0]  alu_out,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [RES_W-1:0]  rsp_result,
   output logic              rsp_zero,
   output logic              rsp_err,
   output logic [DATA_W-1:0] acc
);

   localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

   logic [1:0]        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] alu_in_a_q, alu_in_a_d;
   logic [DATA_W-1:0] alu_in_b_q, alu_in_b_d;
   logic [DATA_W-1:0] alu_opcode_q, alu_opcode_d;
   logic [RES_W-1:0]  rsp_result_q, rsp_result_d;
   logic              rsp_zero_q, rsp_zero_d;
   logic              rsp_err_q, rsp_err_d;
   logic [DATA_W-1:0] acc_q, acc_d;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      alu_in_a_d   = alu_in_a_q;
      alu_in_b_d   = alu_in_b_q;
      alu_opcode_d = alu_opcode_q;
      rsp_result_d = rsp_result_q;
      rsp_zero_d   = rsp_zero_q;
      rsp_err_d    = rsp_err_q;
      acc_d        = acc_q;

      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               if (is_legal_op(cmd_opcode)) begin
                  alu_in_a_d   = cmd_use_acc ? acc_q : cmd_a;
                  alu_in_b_d   = cmd_b;
                  alu_opcode_d = cmd_opcode;
                  cnt_d        = CNT_LOAD;
                  state_d      = ST_SETTLE;
               end else begin
                  // Illegal opcode never reaches the ALU: inputs keep their
                  // last legal values and the error is answered directly.
                  rsp_err_d    = 1'b1;
                  rsp_result_d = '0;
                  rsp_zero_d   = 1'b0;
                  state_d      = ST_RESP;
               end
            end
         end
         ST_SETTLE: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               rsp_result_d = alu_out;
               rsp_zero_d   = (alu_out[DATA_W-1:0] == '0);
               rsp_err_d    = 1'b0;
               acc_d        = alu_out[DATA_W-1:0];
               state_d      = ST_RESP;
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         alu_in_a_q   <= '0;
         alu_in_b_q   <= '0;
         alu_opcode_q <= OP_ADD;   // 0 + 0 with ADD keeps the ALU output at 0
         rsp_result_q <= '0;
         rsp_zero_q   <= 1'b0;
         rsp_err_q    <= 1'b0;
         acc_q        <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         alu_in_a_q   <= alu_in_a_d;
         alu_in_b_q   <= alu_in_b_d;
         alu_opcode_q <= alu_opcode_d;
         rsp_result_q <= rsp_result_d;
         rsp_zero_q   <= rsp_zero_d;
         rsp_err_q    <= rsp_err_d;
         acc_q        <= acc_d;
      end
   end

   assign cmd_ready  = (state_q == ST_IDLE);
   assign rsp_valid  = (state_q == ST_RESP);
   assign alu_in_a   = alu_in_a_q;
   assign alu_in_b   = alu_in_b_q;
   assign alu_opcode = alu_opcode_q;
   assign rsp_result = rsp_result_q;
   assign rsp_zero   = rsp_zero_q;
   assign rsp_err    = rsp_err_q;
   assign acc        = acc_q;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Bench for alu_cmd_issuer: two instances (SETTLE_CYCLES=1 and 3), each wired
// to a behavioural ALU, checked every cycle against a transaction-level model.
// Directed scenarios pin the model with literal values, then random traffic.
module tb_alu_cmd_issuer;

   logic       clk = 1'b0;
   logic       rst_n       [2];
   logic       cmd_valid   [2];
   logic       cmd_ready   [2];
   logic [3:0] cmd_opcode  [2];
   logic [3:0] cmd_a       [2];
   logic [3:0] cmd_b       [2];
   logic       cmd_use_acc [2];
   logic [3:0] alu_in_a    [2];
   logic [3:0] alu_in_b    [2];
   logic [3:0] alu_opcode  [2];
   logic [4:0] alu_out     [2];
   logic       rsp_valid   [2];
   logic       rsp_ready   [2];
   logic [4:0] rsp_result  [2];
   logic       rsp_zero    [2];
   logic       rsp_err     [2];
   logic [3:0] acc         [2];

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   // ALU behaviour: 5-bit arithmetic on zero-extended 4-bit operands.
   function automatic logic [4:0] alu_ref(input logic [3:0] a, input logic [3:0] b,
                                          input logic [3:0] op);
      int x;
      int y;
      int r;
      x = int'(a);
      y = int'(b);
      case (op)
         4'd3:    r = x + y;
         4'd4:    r = x - y;
         4'd5:    r = x & y;
         4'd6:    r = ~(x & y);
         4'd7:    r = x | y;
         4'd8:    r = ~(x | y);
         4'd9:    r = x ^ y;
         4'd10:   r = ~(x ^ y);
         default: r = 0;
      endcase
      return r[4:0];
   endfunction

   function automatic bit legal(input logic [3:0] op);
      return (op >= 4'd3) && (op <= 4'd10);
   endfunction

   function automatic int settle_of(input int k);
      return (k == 0) ? 1 : 3;
   endfunction

   task automatic chk(input int k, input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL dut%0d %s: got %0h expected %0h at %0t", k, nm, act, exp, $time);
      end
   endtask

   for (genvar k = 0; k < 2; k++) begin : g_dut
      localparam int S = (k == 0) ? 1 : 3;

      alu_cmd_issuer #(.SETTLE_CYCLES(S)) u_dut (
         .clk        (clk),
         .rst_n      (rst_n[k]),
         .cmd_valid  (cmd_valid[k]),
         .cmd_ready  (cmd_ready[k]),
         .cmd_opcode (cmd_opcode[k]),
         .cmd_a      (cmd_a[k]),
         .cmd_b      (cmd_b[k]),
         .cmd_use_acc(cmd_use_acc[k]),
         .alu_in_a   (alu_in_a[k]),
         .alu_in_b   (alu_in_b[k]),
         .alu_opcode (alu_opcode[k]),
         .alu_out    (alu_out[k]),
         .rsp_valid  (rsp_valid[k]),
         .rsp_ready  (rsp_ready[k]),
         .rsp_result (rsp_result[k]),
         .rsp_zero   (rsp_zero[k]),
         .rsp_err    (rsp_err[k]),
         .acc        (acc[k])
      );

      assign alu_out[k] = alu_ref(alu_in_a[k], alu_in_b[k], alu_opcode[k]);

      // Transaction model: one command in flight; m_wait counts edges left
      // until the response appears, m_rsp says a response is on offer.
      bit         m_rsp  = 1'b0;
      int         m_wait = 0;
      logic [4:0] p_res  = '0;
      logic [4:0] m_res  = '0;
      logic       m_zero = 1'b0;
      logic       m_err  = 1'b0;
      logic [3:0] m_acc  = '0;
      logic [3:0] m_a    = '0;
      logic [3:0] m_b    = '0;
      logic [3:0] m_op   = 4'd3;

      always @(posedge clk or negedge rst_n[k]) begin
         logic [3:0] opa;
         if (!rst_n[k]) begin
            m_rsp = 1'b0; m_wait = 0; m_res = '0; m_zero = 1'b0; m_err = 1'b0;
            m_acc = '0; m_a = '0; m_b = '0; m_op = 4'd3;
         end else if (m_rsp) begin
            if (rsp_ready[k]) m_rsp = 1'b0;
         end else if (m_wait > 0) begin
            m_wait = m_wait - 1;
            if (m_wait == 0) begin
               m_rsp = 1'b1; m_res = p_res; m_zero = (p_res[3:0] == 4'd0);
               m_err = 1'b0; m_acc = p_res[3:0];
            end
         end else if (cmd_valid[k]) begin
            opa = cmd_use_acc[k] ? m_acc : cmd_a[k];
            if (legal(cmd_opcode[k])) begin
               m_a = opa; m_b = cmd_b[k]; m_op = cmd_opcode[k];
               p_res = alu_ref(opa, cmd_b[k], cmd_opcode[k]);
               m_wait = S;
            end else begin
               m_rsp = 1'b1; m_err = 1'b1; m_res = '0; m_zero = 1'b0;
            end
         end
      end

      always @(negedge clk) begin
         chk(k, "cmd_ready", cmd_ready[k], (!m_rsp && m_wait == 0));
         chk(k, "rsp_valid", rsp_valid[k], m_rsp);
         chk(k, "acc", acc[k], m_acc);
         chk(k, "alu_in_a", alu_in_a[k], m_a);
         chk(k, "alu_in_b", alu_in_b[k], m_b);
         chk(k, "alu_opcode", alu_opcode[k], m_op);
         if (m_rsp) begin
            chk(k, "rsp_result", rsp_result[k], m_res);
            chk(k, "rsp_zero", rsp_zero[k], m_zero);
            chk(k, "rsp_err", rsp_err[k], m_err);
         end
      end
   end

   // Issue one command, wait for its response, hold rsp_ready low for
   // 'hold' cycles, then take it. lat counts the accept cycle as 1.
   task automatic send(input int k, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] op, input logic ua, input int hold,
                       output logic [4:0] res, output logic z, output logic e,
                       output int lat);
      int n;
      @(negedge clk);
      cmd_a[k] = a; cmd_b[k] = b; cmd_opcode[k] = op; cmd_use_acc[k] = ua;
      cmd_valid[k] = 1'b1; rsp_ready[k] = 1'b0;
      n = 0;
      while (!cmd_ready[k] && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk(k, "accept_timeout", cmd_ready[k], 1);
      @(posedge clk);
      @(negedge clk);
      // Junk on the command bus must be ignored once the command is taken.
      cmd_valid[k] = 1'b0; cmd_a[k] = 4'($urandom); cmd_b[k] = 4'($urandom);
      cmd_opcode[k] = 4'($urandom); cmd_use_acc[k] = 1'($urandom);
      lat = 1;
      while (!rsp_valid[k] && lat < 50) begin
         @(negedge clk);
         lat++;
      end
      repeat (hold) @(negedge clk);
      res = rsp_result[k]; z = rsp_zero[k]; e = rsp_err[k];
      rsp_ready[k] = 1'b1;
      @(negedge clk);
      rsp_ready[k] = 1'b0;
   endtask

   task automatic reset_vals(input int k, input string tag);
      chk(k, {tag, "_cmd_ready"}, cmd_ready[k], 1);
      chk(k, {tag, "_rsp_valid"}, rsp_valid[k], 0);
      chk(k, {tag, "_rsp_result"}, rsp_result[k], 0);
      chk(k, {tag, "_rsp_zero"}, rsp_zero[k], 0);
      chk(k, {tag, "_rsp_err"}, rsp_err[k], 0);
      chk(k, {tag, "_acc"}, acc[k], 0);
      chk(k, {tag, "_alu_in_a"}, alu_in_a[k], 0);
      chk(k, {tag, "_alu_in_b"}, alu_in_b[k], 0);
      chk(k, {tag, "_alu_opcode"}, alu_opcode[k], 3);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [4:0] res;
      logic       z;
      logic       e;
      logic [3:0] op;
      int         lat;
      int         n;
      for (int k = 0; k < 2; k++) begin
         rst_n[k] = 1'b0; cmd_valid[k] = 1'b0; cmd_a[k] = '0; cmd_b[k] = '0;
         cmd_opcode[k] = '0; cmd_use_acc[k] = 1'b0; rsp_ready[k] = 1'b0;
      end
      repeat (2) @(negedge clk);
      for (int k = 0; k < 2; k++) reset_vals(k, "por");
      rst_n[0] = 1'b1; rst_n[1] = 1'b1;
      repeat (2) @(negedge clk);

      for (int k = 0; k < 2; k++) begin
         // ADD 9+8
         send(k, 4'd9, 4'd8, 4'd3, 1'b0, 0, res, z, e, lat);
         chk(k, "add_res", res, 5'h11); chk(k, "add_zero", z, 0);
         chk(k, "add_err", e, 0); chk(k, "add_acc", acc[k], 4'd1);
         chk(k, "add_lat", lat, settle_of(k) + 1);
         // SUB with borrow
         send(k, 4'd3, 4'd5, 4'd4, 1'b0, 0, res, z, e, lat);
         chk(k, "sub_res", res, 5'h1E); chk(k, "sub_acc", acc[k], 4'hE);
         // Illegal opcodes leave ALU inputs and acc alone
         send(k, 4'd7, 4'd7, 4'd0, 1'b0, 0, res, z, e, lat);
         chk(k, "ill0_err", e, 1); chk(k, "ill0_res", res, 0);
         chk(k, "ill0_lat", lat, 1); chk(k, "ill0_op", alu_opcode[k], 4'd4);
         chk(k, "ill0_acc", acc[k], 4'hE);
         send(k, 4'd1, 4'd1, 4'd15, 1'b0, 2, res, z, e, lat);
         chk(k, "ill15_err", e, 1); chk(k, "ill15_res", res, 0);
         chk(k, "ill15_zero", z, 0); chk(k, "ill15_lat", lat, 1);
         chk(k, "ill15_op", alu_opcode[k], 4'd4); chk(k, "ill15_acc", acc[k], 4'hE);
         // Chain from acc: E+2 (cmd_a ignored)
         send(k, 4'd9, 4'd2, 4'd3, 1'b1, 0, res, z, e, lat);
         chk(k, "chain_res", res, 5'h10); chk(k, "chain_zero", z, 1);
         chk(k, "chain_acc", acc[k], 4'd0); chk(k, "chain_in_a", alu_in_a[k], 4'hE);
         // XNOR
         send(k, 4'hA, 4'h5, 4'd10, 1'b0, 1, res, z, e, lat);
         chk(k, "xnor_res", res, 5'h10); chk(k, "xnor_zero", z, 1);

         // Backpressure with the next command held on the bus
         @(negedge clk);
         cmd_a[k] = 4'd2; cmd_b[k] = 4'd3; cmd_opcode[k] = 4'd3; cmd_use_acc[k] = 1'b0;
         cmd_valid[k] = 1'b1; rsp_ready[k] = 1'b0;
         @(posedge clk);
         @(negedge clk);
         cmd_a[k] = 4'd7; cmd_b[k] = 4'd1; cmd_opcode[k] = 4'd9;
         n = 0;
         while (!rsp_valid[k] && n < 50) begin
            @(negedge clk);
            n++;
         end
         for (int i = 0; i < 5; i++) begin
            chk(k, "bp_valid", rsp_valid[k], 1); chk(k, "bp_ready", cmd_ready[k], 0);
            chk(k, "bp_res", rsp_result[k], 5'h05); chk(k, "bp_op", alu_opcode[k], 4'd3);
            @(negedge clk);
         end
         rsp_ready[k] = 1'b1;
         @(negedge clk);
         rsp_ready[k] = 1'b0;
         chk(k, "bp_idle_ready", cmd_ready[k], 1);
         chk(k, "bp_idle_op", alu_opcode[k], 4'd3);
         @(negedge clk);
         cmd_valid[k] = 1'b0;
         chk(k, "bp_next_op", alu_opcode[k], 4'd9); chk(k, "bp_next_a", alu_in_a[k], 4'd7);
         n = 0;
         while (!rsp_valid[k] && n < 50) begin
            @(negedge clk);
            n++;
         end
         chk(k, "bp_next_res", rsp_result[k], 5'h06);
         rsp_ready[k] = 1'b1;
         @(negedge clk);
         rsp_ready[k] = 1'b0;

         // Random traffic
         for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 3) == 0) op = 4'($urandom_range(0, 15));
            else op = 4'($urandom_range(3, 10));
            send(k, 4'($urandom), 4'($urandom), op, 1'($urandom), $urandom_range(0, 3),
                 res, z, e, lat);
            chk(k, "rnd_lat", lat, legal(op) ? settle_of(k) + 1 : 1);
            chk(k, "rnd_err", e, !legal(op));
         end
      end

      // Reset during SETTLE on the SETTLE_CYCLES=3 instance
      send(1, 4'd1, 4'd1, 4'd3, 1'b0, 0, res, z, e, lat);
      chk(1, "pre_rst_acc", acc[1], 4'd2);
      @(negedge clk);
      cmd_a[1] = 4'd4; cmd_b[1] = 4'd4; cmd_opcode[1] = 4'd3; cmd_use_acc[1] = 1'b0;
      cmd_valid[1] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      cmd_valid[1] = 1'b0;
      chk(1, "pre_rst_op_a", alu_in_a[1], 4'd4);
      @(posedge clk);
      #2;
      rst_n[1] = 1'b0;
      #1;
      reset_vals(1, "arst");
      repeat (2) @(negedge clk);
      rst_n[1] = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk(1, "post_rst_no_rsp", rsp_valid[1], 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
